// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - main control FSM for the multicycle datapath with memory-ready timeout.
// Optional performance counters are built when MCTRL_PERF_EN is defined.

module multicycle_ctrl #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  Op,
  input  logic [1:0]  Funct,
  input  logic        Ibit,
  input  logic        Zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        MemWrite,
  output logic        AdrSrc,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        RegWrite,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ALUControl,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ImmSrc,
  output logic        halted,
  output logic        fault
`ifdef MCTRL_PERF_EN
  ,
  output logic [31:0] perf_cycles,
  output logic [31:0] perf_instrs
`endif
);

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC_R,
    S_EXEC_I,
    S_ALU_WB,
    S_MEM_ADR,
    S_MEM_RD,
    S_MEM_WB,
    S_MEM_WR,
    S_BRANCH,
    S_HALT,
    S_FAULT
  } state_t;

  // The counter never holds TIMEOUT_CYCLES itself: the wait cycle that would
  // bring it there diverts straight to FAULT.
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           r_state;
  state_t           w_next;
  logic [1:0]       r_op;
  logic [1:0]       r_funct;
  logic             r_ibit;
  logic [CNT_W-1:0] r_wait;

  logic w_req;
  logic w_wait;
  logic w_timeout;
  logic w_memwrite;
  logic w_irwrite;
  logic w_pcwrite;
  logic w_regwrite;

  function automatic logic [1:0] imm_mode(input logic [1:0] op);
    return (op == 2'b11) ? 2'b00 : op;
  endfunction

  assign w_req     = (r_state == S_FETCH) || (r_state == S_MEM_RD) || (r_state == S_MEM_WR);
  assign w_wait    = w_req && !mem_ready;
  assign w_timeout = w_wait && (r_wait == WAIT_LAST);

  always_comb begin
    w_next     = r_state;
    w_memwrite = 1'b0;
    w_irwrite  = 1'b0;
    w_pcwrite  = 1'b0;
    w_regwrite = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUControl = 2'b00;
    ResultSrc  = 2'b00;
    ImmSrc     = imm_mode(r_op);

    case (r_state)
      S_FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        if (mem_ready) begin
          w_irwrite = 1'b1;
          w_pcwrite = 1'b1;
          w_next    = S_DECODE;
        end
      end
      S_DECODE: begin
        ImmSrc = imm_mode(Op);
        case (Op)
          2'b00:   w_next = Ibit ? S_EXEC_I : S_EXEC_R;
          2'b01:   w_next = S_MEM_ADR;
          2'b10:   w_next = S_BRANCH;
          default: w_next = S_HALT;
        endcase
      end
      S_EXEC_R, S_EXEC_I: begin
        // r_ibit is 1 exactly in EXEC_I, so it selects the ExtImm operand.
        ALUSrcA    = 1'b1;
        ALUSrcB    = {1'b0, r_ibit};
        ALUControl = r_funct;
        w_next     = S_ALU_WB;
      end
      S_ALU_WB: begin
        w_regwrite = 1'b1;
        ResultSrc  = 2'b00;
        w_next     = S_FETCH;
      end
      S_MEM_ADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b01;
        w_next  = r_funct[0] ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        AdrSrc = 1'b1;
        if (mem_ready) w_next = S_MEM_WB;
      end
      S_MEM_WB: begin
        w_regwrite = 1'b1;
        ResultSrc  = 2'b01;
        w_next     = S_FETCH;
      end
      S_MEM_WR: begin
        AdrSrc     = 1'b1;
        w_memwrite = 1'b1;
        if (mem_ready) w_next = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        w_pcwrite = (r_funct == 2'b00) || ((r_funct == 2'b01) && Zero);
        w_next    = S_FETCH;
      end
      S_HALT, S_FAULT: begin
        w_next = r_state;
      end
      default: w_next = S_FETCH;
    endcase

    if (w_timeout) w_next = S_FAULT;
  end

  // Strobes are gated by reset so nothing escapes during an asynchronous abort.
  assign mem_req  = w_req      && !reset;
  assign MemWrite = w_memwrite && !reset;
  assign IRWrite  = w_irwrite  && !reset;
  assign PCWrite  = w_pcwrite  && !reset;
  assign RegWrite = w_regwrite && !reset;
  assign halted   = (r_state == S_HALT);
  assign fault    = (r_state == S_FAULT);

`ifdef MCTRL_PERF_EN
  logic [31:0] r_perf_cycles;
  logic [31:0] r_perf_instrs;

  assign perf_cycles = r_perf_cycles;
  assign perf_instrs = r_perf_instrs;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_op    <= 2'b00;
      r_funct <= 2'b00;
      r_ibit  <= 1'b0;
      r_wait  <= '0;
`ifdef MCTRL_PERF_EN
      r_perf_cycles <= '0;
      r_perf_instrs <= '0;
`endif
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) begin
        r_op    <= Op;
        r_funct <= Funct;
        r_ibit  <= Ibit;
      end
      r_wait <= (w_wait && !w_timeout) ? r_wait + CNT_W'(1) : '0;
`ifdef MCTRL_PERF_EN
      if ((r_state != S_HALT) && (r_state != S_FAULT)) r_perf_cycles <= r_perf_cycles + 32'd1;
      if ((r_state == S_FETCH) && mem_ready) r_perf_instrs <= r_perf_instrs + 32'd1;
`endif
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - instruction-level checks of multicycle_ctrl with a scoreboard queue.

module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] Op = 2'b00;
  logic [1:0] Funct = 2'b00;
  logic       Ibit = 1'b0;
  logic       Zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, ALUControl, ResultSrc, ImmSrc;
  logic       halted, fault;
`ifdef MCTRL_PERF_EN
  logic [31:0] perf_cycles, perf_instrs;
`endif

  multicycle_ctrl #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Ibit(Ibit), .Zero(Zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .MemWrite(MemWrite), .AdrSrc(AdrSrc),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .ResultSrc(ResultSrc), .ImmSrc(ImmSrc),
    .halted(halted), .fault(fault)
`ifdef MCTRL_PERF_EN
    , .perf_cycles(perf_cycles), .perf_instrs(perf_instrs)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int op, funct, ibit, zero, fwait, dwait;
    int cyc, regw, memw, pcw, imm, alu, srcb, rs, dreq;
  } vec_t;

  vec_t tbl[14];
  vec_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int op, funct, ibit, zero, fwait, dwait,
                              input int cyc, regw, memw, pcw, imm, alu, srcb, rs, dreq);
    vec_t v;
    v.op = op; v.funct = funct; v.ibit = ibit; v.zero = zero; v.fwait = fwait; v.dwait = dwait;
    v.cyc = cyc; v.regw = regw; v.memw = memw; v.pcw = pcw; v.imm = imm; v.alu = alu;
    v.srcb = srcb; v.rs = rs; v.dreq = dreq;
    return v;
  endfunction

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    mem_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  // Runs one instruction starting in FETCH; ends at the negedge of the next FETCH.
  task automatic run_instr(input int idx, input vec_t v);
    int fc, dc, ir_i, rw, mw, pw, dq, last_rw, immbad, cyc, imm, alu, srcb, rs, done;
    vec_t e;
    sb_q.push_back(v);
    Op = v.op[1:0]; Funct = v.funct[1:0]; Ibit = v.ibit[0]; Zero = v.zero[0];
    fc = 0; dc = 0; ir_i = -1; rw = 0; mw = 0; pw = 0; dq = 0; last_rw = -1; immbad = 0;
    cyc = 0; imm = 0; alu = 0; srcb = 0; rs = 3; done = 0;
    for (int i = 0; i < 60; i++) begin
      if (i > 0) @(negedge clk);
      if (ir_i >= 0 && i > ir_i && mem_req && !AdrSrc) begin
        cyc = i;
        done = 1;
        break;
      end
      if (mem_req && !AdrSrc) begin
        mem_ready = (fc == v.fwait);
        if (!mem_ready) fc++;
      end else if (mem_req) begin
        mem_ready = (dc == v.dwait);
        if (!mem_ready) dc++;
        dq++;
      end else begin
        mem_ready = 1'b0;
      end
      #1;
      if (IRWrite) ir_i = i;
      if (RegWrite) begin rw++; rs = int'(ResultSrc); last_rw = i; end
      if (MemWrite) mw++;
      if (PCWrite && !IRWrite) pw++;
      if (ir_i >= 0 && i == ir_i + 1) imm = int'(ImmSrc);
      if (ir_i >= 0 && i > ir_i + 1 && int'(ImmSrc) != imm) immbad++;
      if (ir_i >= 0 && i == ir_i + 2) begin alu = int'(ALUControl); srcb = int'(ALUSrcB); end
    end
    e = sb_q.pop_front();
    chk($sformatf("v%0d_done", idx), done, 1);
    chk($sformatf("v%0d_cycles", idx), cyc, e.cyc);
    chk($sformatf("v%0d_regwrite", idx), rw, e.regw);
    chk($sformatf("v%0d_memwrite", idx), mw, e.memw);
    chk($sformatf("v%0d_pcwrite", idx), pw, e.pcw);
    chk($sformatf("v%0d_immsrc", idx), imm, e.imm);
    chk($sformatf("v%0d_imm_stable", idx), immbad, 0);
    chk($sformatf("v%0d_alucontrol", idx), alu, e.alu);
    chk($sformatf("v%0d_alusrcb", idx), srcb, e.srcb);
    chk($sformatf("v%0d_resultsrc", idx), rs, e.rs);
    chk($sformatf("v%0d_data_req", idx), dq, e.dreq);
    if (e.regw > 0) chk($sformatf("v%0d_wb_last", idx), last_rw, e.cyc - 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int n, got;
    //            op f  ib z  fw  dw  cyc rw mw pw imm alu srcb rs dq
    tbl[0]  = mk(0, 0, 0, 0, 0,  0,  4,  1, 0, 0, 0,  0,  0,   0, 0);
    tbl[1]  = mk(0, 1, 1, 0, 0,  0,  4,  1, 0, 0, 0,  1,  1,   0, 0);
    tbl[2]  = mk(0, 2, 0, 0, 2,  0,  6,  1, 0, 0, 0,  2,  0,   0, 0);
    tbl[3]  = mk(0, 3, 1, 1, 0,  0,  4,  1, 0, 0, 0,  3,  1,   0, 0);
    tbl[4]  = mk(1, 1, 0, 0, 0,  3,  8,  1, 0, 0, 1,  0,  1,   1, 4);
    tbl[5]  = mk(1, 1, 0, 0, 0,  0,  5,  1, 0, 0, 1,  0,  1,   1, 1);
    tbl[6]  = mk(1, 0, 0, 0, 0,  0,  4,  0, 1, 0, 1,  0,  1,   3, 1);
    tbl[7]  = mk(1, 0, 0, 0, 1,  2,  7,  0, 3, 0, 1,  0,  1,   3, 3);
    tbl[8]  = mk(2, 0, 0, 0, 0,  0,  3,  0, 0, 1, 2,  0,  1,   3, 0);
    tbl[9]  = mk(2, 1, 0, 0, 0,  0,  3,  0, 0, 0, 2,  0,  1,   3, 0);
    tbl[10] = mk(2, 1, 0, 1, 0,  0,  3,  0, 0, 1, 2,  0,  1,   3, 0);
    tbl[11] = mk(2, 2, 0, 1, 0,  0,  3,  0, 0, 0, 2,  0,  1,   3, 0);
    tbl[12] = mk(2, 3, 0, 1, 0,  0,  3,  0, 0, 0, 2,  0,  1,   3, 0);
    tbl[13] = mk(0, 0, 0, 0, 15, 0,  19, 1, 0, 0, 0,  0,  0,   0, 0);

    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    mem_ready = 1'b1;
    #1;
    chk("rst_mem_req", int'(mem_req), 0);
    chk("rst_memwrite", int'(MemWrite), 0);
    chk("rst_irwrite", int'(IRWrite), 0);
    chk("rst_pcwrite", int'(PCWrite), 0);
    chk("rst_regwrite", int'(RegWrite), 0);
    chk("rst_halted", int'(halted), 0);
    chk("rst_fault", int'(fault), 0);
    chk("rst_alusrcb", int'(ALUSrcB), 2);
    chk("rst_resultsrc", int'(ResultSrc), 2);
    chk("rst_immsrc", int'(ImmSrc), 0);
    mem_ready = 1'b0;
    reset = 1'b0;
    #1;
    chk("first_mem_req", int'(mem_req), 1);

    for (int k = 0; k < 14; k++) run_instr(k, tbl[k]);

    Op = 2'b11; Funct = 2'b00; Ibit = 1'b0;
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    chk("halt_decode_immsrc", int'(ImmSrc), 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      mem_ready = 1'b1;
      #1;
      chk("halt_halted", int'(halted), 1);
      chk("halt_mem_req", int'(mem_req), 0);
    end
    pulse_reset();
    chk("halt_cleared", int'(halted), 0);

    Op = 2'b00; Funct = 2'b00;
    mem_ready = 1'b0;
    n = 0; got = 0;
    for (int i = 0; i < 40; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      if (fault) begin got = 1; break; end
      if (mem_req) n++;
    end
    chk("fault_reached", got, 1);
    chk("fault_wait_cycles", n, 16);
    mem_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      chk("fault_sticky", int'(fault), 1);
      chk("fault_mem_req", int'(mem_req), 0);
      chk("fault_irwrite", int'(IRWrite), 0);
    end
    pulse_reset();
    chk("fault_cleared", int'(fault), 0);
    chk("fault_refetch", int'(mem_req), 1);

    Op = 2'b01; Funct = 2'b00;
    mem_ready = 1'b1;
    got = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      if (MemWrite) begin got = 1; break; end
    end
    chk("memwr_reached", got, 1);
    mem_ready = 1'b0;
    reset = 1'b1;
    #1;
    chk("memwr_rst_memwrite", int'(MemWrite), 0);
    chk("memwr_rst_mem_req", int'(mem_req), 0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("memwr_resume_req", int'(mem_req), 1);
    chk("memwr_resume_adrsrc", int'(AdrSrc), 0);
    chk("memwr_resume_memwrite", int'(MemWrite), 0);

`ifdef MCTRL_PERF_EN
    for (int k = 0; k < 3; k++) run_instr(100 + k, tbl[0]);
    Op = 2'b11;
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    @(negedge clk);
    #1;
    chk("perf_halted", int'(halted), 1);
    chk("perf_instrs", int'(perf_instrs), 4);
    chk("perf_cycles", int'(perf_cycles), 14);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
